// File: rtl/seq_divider32.sv
// Iterative radix-2 restoring divider producing one quotient bit per clock.
// Define SIGNED_DIV_EN to add the signed_op input for two's-complement division.
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             zero_q, zero_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg_s, dvs_neg_s;
    logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
    logic [WIDTH:0]   shifted_s, trial_s, rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

`ifdef SIGNED_DIV_EN
    assign dvd_neg_s = signed_op & dividend[WIDTH-1];
    assign dvs_neg_s = signed_op & divisor[WIDTH-1];
`else
    assign dvd_neg_s = 1'b0;
    assign dvs_neg_s = 1'b0;
`endif

    // Signed operands are reduced to magnitudes; the iteration itself is always unsigned.
    assign dvd_mag_s = dvd_neg_s ? negate(dividend) : dividend;
    assign dvs_mag_s = dvs_neg_s ? negate(divisor) : divisor;

    // One restoring step: shift the next dividend bit into R and trial-subtract the divisor.
    always_comb begin
        shifted_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvsr_q};
        if (!trial_s[WIDTH]) begin
            rem_step_s = trial_s;
            quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = shifted_s;
            quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-output logic for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        zero_d      = zero_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d   = CALC;
                    dvsr_d    = dvs_mag_s;
                    quo_d     = dvd_mag_s;
                    neg_quo_d = dvd_neg_s ^ dvs_neg_s;
                    neg_rem_d = dvd_neg_s;
                    if (divisor == {WIDTH{1'b0}}) begin
                        // Zero divisor skips the iterations; R carries the raw dividend to the result.
                        zero_d  = 1'b1;
                        count_d = {CW{1'b0}};
                        rem_d   = {1'b0, dividend};
                    end else begin
                        zero_d  = 1'b0;
                        count_d = CW'(WIDTH - 1);
                        rem_d   = {(WIDTH+1){1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d   = rem_step_s;
                quo_d   = quo_step_s;
                count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                if (count_q == {CW{1'b0}}) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    if (zero_q) begin
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = rem_q[WIDTH-1:0];
                        dbz_d       = 1'b1;
                    end else begin
                        quotient_d  = neg_quo_q ? negate(quo_step_s) : quo_step_s;
                        remainder_d = neg_rem_q ? negate(rem_step_s[WIDTH-1:0])
                                                : rem_step_s[WIDTH-1:0];
                        dbz_d       = 1'b0;
                    end
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= {CW{1'b0}};
            rem_q       <= {(WIDTH+1){1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dvsr_q      <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            zero_q      <= zero_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Randomized scoreboard bench for seq_divider32; signed cases run when SIGNED_DIV_EN is defined.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        signed_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef SIGNED_DIV_EN
        .signed_op  (signed_op),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    bit   mon_seen = 1'b0;
    int   wait_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention applied explicitly.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t e;
        longint sa, sb_v;
        e.acc = 0;
        e.hold = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dz = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb_v = longint'($signed(b));
            e.q = 32'(sa / sb_v);
            e.r = 32'(sa % sb_v);
            e.dz = 1'b0;
            e.lat = 32;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
            e.lat = 32;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int hold, input bit pulse);
        exp_t e;
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor = b;
        signed_op = s;
        @(posedge clk);
        #1;
        e = model(a, b, s);
        e.acc = cyc;
        e.hold = hold;
        sb.push_back(e);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        signed_op = ~s;
        if (pulse) begin
            repeat (4) begin
                @(negedge clk);
                in_valid = 1'b1;
                dividend = $urandom;
                divisor = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_div_by_zero"}, div_by_zero, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return $urandom_range(0, 255);
            2: return $urandom >> $urandom_range(0, 31);
            3: return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: return 32'h8000_0000;
        endcase
    endfunction

    // Monitor: pops the scoreboard on each new result and drives out_ready backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_seen && out_ready) begin
                chk("hs_out_valid_low", out_valid, 0);
                chk("hs_in_ready_high", in_ready, 1);
                mon_seen = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid && !mon_seen) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: q=0x%0h r=0x%0h with empty scoreboard",
                             quotient, remainder);
                    out_ready = 1'b1;
                    mon_seen = 1'b1;
                end else begin
                    mon_exp = sb.pop_front();
                    chk("quotient", quotient, mon_exp.q);
                    chk("remainder", remainder, mon_exp.r);
                    chk("div_by_zero", div_by_zero, mon_exp.dz);
                    chk("latency", cyc - mon_exp.acc, mon_exp.lat);
                    chk("busy_done", busy, 1);
                    mon_seen = 1'b1;
                    if (mon_exp.hold > 0) begin
                        out_ready = 1'b0;
                        wait_cnt = mon_exp.hold - 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            end else if (mon_seen) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_quotient", quotient, mon_exp.q);
                chk("hold_remainder", remainder, mon_exp.r);
                chk("hold_div_by_zero", div_by_zero, mon_exp.dz);
                chk("hold_in_ready_low", in_ready, 0);
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Reset while an operation is mid-iteration must discard it entirely.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midcalc_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midcalc_reset");
        rst_n = 1'b1;

        issue(32'd100, 32'd9, 1'b0, 0, 1'b0);
        issue(32'hFFFF_FFFF, 32'h10, 1'b0, 0, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b0, 2, 1'b0);
        issue(32'd50, 32'd5, 1'b0, 10, 1'b1);
        issue(32'hDEAD_BEEF, 32'd0, 1'b0, 10, 1'b1);
        issue(32'd5, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        issue(32'd0, 32'd3, 1'b0, 1, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        issue(32'd0, 32'd0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            issue(rnd_op(), rnd_op(), 1'b0, $urandom_range(0, 3), 1'b0);
        end

`ifdef SIGNED_DIV_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 1, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end
`endif

        t = 0;
        while ((sb.size() != 0 || mon_seen) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || mon_seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
